// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if
// Bundles the bridge's bus-side signals: the core memory port, the RAM
// side-channel and the transmit byte stream.
//   adr, writedata, memwrite : core access (address, store data, store strobe)
//   readdata                 : load data back to the core
//   ram_we, ram_rd           : write enable to and read data from the RAM
//   tx_data, tx_valid        : FIFO head byte and its valid flag
//   tx_ready                 : the byte sink accepts the head byte
// The "master" modport is the environment (core, RAM and byte sink).
// The "slave" modport is the bridge.
interface mmio_bridge_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic        ram_we;
  logic [31:0] ram_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output adr, writedata, memwrite, ram_rd, tx_ready,
    input  readdata, ram_we, tx_data, tx_valid
  );

  modport slave (
    input  adr, writedata, memwrite, ram_rd, tx_ready,
    output readdata, ram_we, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_bridge.sv
// mmio_bridge
// Sends each core access either to RAM or to the I/O page at 0xFFFF_0000.
// The page holds four registers: LED, a free-running cycle counter, the
// transmit FIFO data port, and a FIFO status register.
// Reads are purely combinational and have no side effects.
//   clk   : system clock, rising edge active
//   reset : asynchronous, active-high, clears all state
//   bus   : core port, RAM side-channel and tx stream (slave modport)
//   led   : LED register output
module mmio_bridge (
  input  logic         clk,
  input  logic         reset,
  mmio_bridge_if.slave bus,
  output logic [7:0]   led
);

  localparam int FIFO_DEPTH = 4;

  logic        io_sel;
  logic        reg_sel;
  logic [1:0]  reg_idx;
  logic        wr_led;
  logic        wr_cycle;
  logic        wr_tx;
  logic        wr_status;
  logic [31:0] cycle_count;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;
  logic        ovf;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        unused_bits;

  // Byte lanes and the upper store bits play no part in register decode
  assign unused_bits = ^{bus.adr[1:0], bus.writedata[31:8]};

  // Address decode: the upper half selects the I/O page, and only the
  // first 16 bytes of that page hold registers.
  assign io_sel    = (bus.adr[31:16] == 16'hFFFF);
  assign reg_sel   = io_sel && (bus.adr[15:4] == 12'h000);
  assign reg_idx   = bus.adr[3:2];
  assign wr_led    = bus.memwrite && reg_sel && (reg_idx == 2'd0);
  assign wr_cycle  = bus.memwrite && reg_sel && (reg_idx == 2'd1);
  assign wr_tx     = bus.memwrite && reg_sel && (reg_idx == 2'd2);
  assign wr_status = bus.memwrite && reg_sel && (reg_idx == 2'd3);

  assign bus.ram_we = bus.memwrite & ~io_sel;

  assign empty        = (count == 3'd0);
  assign full         = (count == 3'd4);
  assign bus.tx_valid = ~empty;
  assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign pop          = bus.tx_valid & bus.tx_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign push_ok      = wr_tx && (!full || pop);

  // Load data mux: RAM data outside the page, zero for unmapped page addresses
  always_comb begin
    bus.readdata = bus.ram_rd;
    if (io_sel) begin
      bus.readdata = 32'h0;
      if (reg_sel) begin
        case (reg_idx)
          2'd0:    bus.readdata = {24'h0, led};
          2'd1:    bus.readdata = cycle_count;
          2'd2:    bus.readdata = 32'h0;
          default: bus.readdata = {26'h0, ovf, empty, full, count};
        endcase
      end
    end
  end

  // LED register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= 8'h00;
    end else if (wr_led) begin
      led <= bus.writedata[7:0];
    end
  end

  // Cycle counter: a write loads zero instead of incrementing on that edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'h0;
    end else if (wr_cycle) begin
      cycle_count <= 32'h0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Transmit FIFO: circular buffer whose pointers wrap naturally at 2 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= 8'h00;
      end
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= bus.writedata[7:0];
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + {2'b00, push_ok} - {2'b00, pop};
    end
  end

  // Sticky overflow flag: set by a dropped push, cleared by writing 1 to bit 5.
  // Both cannot happen on one edge because they use different addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr_tx && !push_ok) begin
      ovf <= 1'b1;
    end else if (wr_status && bus.writedata[5]) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge
// Self-checking bench for mmio_bridge. A behavioural model keeps the LED
// value, the counter value, a byte queue and the overflow flag. Every falling
// edge, the model's expected outputs are compared with the DUT outputs.
// Directed sequences pin the model to hand-computed values. A randomized
// phase then exercises the decode, the FIFO and the counter.
module tb_mmio_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led;

  mmio_bridge_if bus_if ();

  mmio_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .led   (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [7:0]  m_led   = 8'h00;
  logic [31:0] m_cycle = 32'h0;
  logic        m_ovf   = 1'b0;
  logic [7:0]  m_q[$];

  logic [31:0] m_word;
  logic        m_wr;
  logic        m_popped;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] status_word();
    logic [2:0] cnt;
    cnt = 3'(m_q.size());
    return {26'h0, m_ovf, (m_q.size() == 0), (m_q.size() == 4), cnt};
  endfunction

  // Expected load data, worked out from the register map
  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (a[31:16] != 16'hFFFF) return rd;
    case (w)
      32'hFFFF_0000: return {24'h0, m_led};
      32'hFFFF_0004: return m_cycle;
      32'hFFFF_000C: return status_word();
      default:       return 32'h0;
    endcase
  endfunction

  // Model update on each clock edge: pop first, then push into whatever room is left
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_led   = 8'h00;
      m_cycle = 32'h0;
      m_ovf   = 1'b0;
      m_q.delete();
    end else begin
      m_wr     = bus_if.memwrite;
      m_word   = bus_if.adr & 32'hFFFF_FFFC;
      m_popped = (m_q.size() > 0) && bus_if.tx_ready;
      if (m_popped) void'(m_q.pop_front());
      if (m_wr && m_word == 32'hFFFF_0008) begin
        if (m_q.size() < 4) m_q.push_back(bus_if.writedata[7:0]);
        else m_ovf = 1'b1;
      end
      if (m_wr && m_word == 32'hFFFF_000C && bus_if.writedata[5]) m_ovf = 1'b0;
      if (m_wr && m_word == 32'hFFFF_0000) m_led = bus_if.writedata[7:0];
      m_cycle = (m_wr && m_word == 32'hFFFF_0004) ? 32'h0 : m_cycle + 32'd1;
    end
  end

  // Per-cycle compare of every DUT output against the model
  always @(negedge clk) begin
    checkOutput("readdata", bus_if.readdata, exp_read(bus_if.adr, bus_if.ram_rd));
    checkOutput("ram_we", {31'h0, bus_if.ram_we},
                {31'h0, bus_if.memwrite && (bus_if.adr[31:16] != 16'hFFFF)});
    checkOutput("led", {24'h0, led}, {24'h0, m_led});
    checkOutput("tx_valid", {31'h0, bus_if.tx_valid}, {31'h0, m_q.size() != 0});
    checkOutput("tx_data", {24'h0, bus_if.tx_data},
                {24'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic we, input logic rdy);
    @(negedge clk);
    #1;
    bus_if.adr       = a;
    bus_if.writedata = d;
    bus_if.memwrite  = we;
    bus_if.tx_ready  = rdy;
    bus_if.ram_rd    = $urandom;
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    applyStimulus(a, 32'h0, 1'b0, bus_if.tx_ready);
    #1;
    checkOutput(name, bus_if.readdata, exp);
  endtask

  task automatic push(input logic [7:0] b, input logic rdy);
    applyStimulus(32'hFFFF_0008, {$urandom} & 32'hFFFF_FF00 | {24'h0, b}, 1'b1, rdy);
  endtask

  logic [31:0] r_adr;
  logic [7:0]  drain_exp [4];

  initial begin
    reset            = 1'b1;
    bus_if.adr       = 32'h0;
    bus_if.writedata = 32'h0;
    bus_if.memwrite  = 1'b0;
    bus_if.tx_ready  = 1'b0;
    bus_if.ram_rd    = $urandom;

    // Reset state, then count 10 edges after release
    @(negedge clk);
    #1;
    bus_if.adr = 32'hFFFF_000C;
    #1;
    checkOutput("reset_status", bus_if.readdata, 32'h10);
    checkOutput("reset_led", {24'h0, led}, 32'h0);
    checkOutput("reset_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
    reset      = 1'b0;
    bus_if.adr = 32'hFFFF_0004;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("cycle_after_10", bus_if.readdata, 32'd10);

    // A write clears the counter, which then counts up again
    applyStimulus(32'hFFFF_0004, $urandom, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("cycle_cleared", bus_if.readdata, 32'd0);
    bus_if.memwrite = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cycle_after_clear", bus_if.readdata, 32'd1);

    // Counter wrap
    @(negedge clk);
    #1;
    force dut.cycle_count = 32'hFFFF_FFFF;
    m_cycle = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count;
    #1;
    checkOutput("cycle_max", bus_if.readdata, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    checkOutput("cycle_wrap", bus_if.readdata, 32'h0);

    // LED write and isolation from RAM writes
    applyStimulus(32'hFFFF_0000, 32'h1234_56A5, 1'b1, 1'b0);
    #1;
    checkOutput("led_wr_ram_we", {31'h0, bus_if.ram_we}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("led_a5", {24'h0, led}, 32'hA5);
    applyStimulus(32'h0000_0040, 32'h0000_0077, 1'b1, 1'b0);
    #1;
    checkOutput("ram_we_set", {31'h0, bus_if.ram_we}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("led_kept", {24'h0, led}, 32'hA5);
    readCheck("led_read", 32'hFFFF_0000, 32'h0000_00A5);

    // FIFO fill, overflow and overflow clear
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b0);
    readCheck("status_full", 32'hFFFF_000C, 32'h0C);
    push(8'h55, 1'b0);
    readCheck("status_ovf", 32'hFFFF_000D, 32'h2C);
    checkOutput("head_after_ovf", {24'h0, bus_if.tx_data}, 32'h11);
    readCheck("txdata_reads_zero", 32'hFFFF_0008, 32'h0);
    applyStimulus(32'hFFFF_000C, 32'h0000_0020, 1'b1, 1'b0);
    readCheck("status_ovf_clr", 32'hFFFF_000C, 32'h0C);

    // Drain in order
    drain_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(32'h0000_0100, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("drain_0", {24'h0, bus_if.tx_data}, {24'h0, drain_exp[0]});
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("drain_n", {24'h0, bus_if.tx_data}, {24'h0, drain_exp[i]});
    end
    @(posedge clk);
    #1;
    checkOutput("drain_valid_low", {31'h0, bus_if.tx_valid}, 32'h0);
    readCheck("status_empty", 32'hFFFF_000C, 32'h10);

    // Simultaneous push and pop on a full FIFO
    push(8'h71, 1'b0);
    push(8'h72, 1'b0);
    push(8'h73, 1'b0);
    push(8'h74, 1'b0);
    push(8'h66, 1'b1);
    @(posedge clk);
    #1;
    bus_if.memwrite = 1'b0;
    bus_if.tx_ready = 1'b0;
    bus_if.adr      = 32'hFFFF_000C;
    #1;
    checkOutput("pushpop_status", bus_if.readdata, 32'h0C);
    checkOutput("pushpop_head", {24'h0, bus_if.tx_data}, 32'h72);
    drain_exp = '{8'h73, 8'h74, 8'h66, 8'h00};
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("pushpop_order", {24'h0, bus_if.tx_data}, {24'h0, drain_exp[i]});
    end
    @(posedge clk);
    #1;
    checkOutput("pushpop_drained", bus_if.readdata, 32'h10);

    // Asynchronous reset in the middle of activity
    push(8'hAA, 1'b0);
    push(8'hBB, 1'b0);
    applyStimulus(32'hFFFF_0000, 32'h0000_003C, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("pre_reset_status", bus_if.readdata, 32'h02);
    checkOutput("pre_reset_led", {24'h0, led}, 32'h3C);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
    checkOutput("async_led", {24'h0, led}, 32'h0);
    checkOutput("async_status", bus_if.readdata, 32'h10);
    bus_if.adr = 32'hFFFF_0010;
    #1;
    checkOutput("unmapped_read", bus_if.readdata, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: r_adr = 32'hFFFF_0000 | {28'h0, 2'($urandom_range(0, 3)), 2'($urandom)};
        4:          r_adr = {16'hFFFF, 12'($urandom_range(1, 4095)), 4'($urandom)};
        5:          r_adr = 32'hFFFF_0008;
        default:    r_adr = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)};
      endcase
      applyStimulus(r_adr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
